// File: rtl/ram_latency_model.sv
// Word-addressed single-port backing RAM with a fixed BUSY latency per transaction,
// answering memory_control with the FREE/BUSY/ACCESS/ERROR ramstate handshake.
module ram_latency_model #(
  parameter int LAT   = 2,
  parameter int DEPTH = 16384,
  parameter int IDX_W = 14
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ramREN,
  input  logic        ramWEN,
  input  logic [31:0] ramaddr,
  input  logic [31:0] ramstore,
  output logic [31:0] ramload,
  output logic [1:0]  ramstate,
  input  logic        tbWEN,
  input  logic        tbREN,
  input  logic [31:0] tbaddr,
  input  logic [31:0] tbstore,
  output logic [31:0] tbload
);
  typedef enum logic [1:0] {FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3} ramstate_t;

  logic [31:0] mem [DEPTH];

  logic        valid_q, valid_d;
  logic [31:0] lat_addr_q, lat_addr_d;
  logic        lat_wen_q, lat_wen_d;
  logic [3:0]  cnt_q, cnt_d;

  logic             req, bad, match, access, tb_ok;
  logic [IDX_W-1:0] ridx, tidx;
  ramstate_t        st;

  assign ridx   = ramaddr[IDX_W+1:2];
  assign tidx   = tbaddr[IDX_W+1:2];
  assign req    = ramREN | ramWEN;
  assign bad    = (ramREN & ramWEN) | (ramaddr[1:0] != 2'b00) | (ramaddr[31:2] >= 30'(DEPTH));
  assign tb_ok  = (tbaddr[1:0] == 2'b00) && (tbaddr[31:2] < 30'(DEPTH));
  assign match  = valid_q & req & ~bad & (ramaddr == lat_addr_q) & (ramWEN == lat_wen_q);
  assign access = match & (cnt_q == 4'd0);

  always_comb begin
    st = BUSY;
    if (!nRST)       st = FREE;
    else if (!req)   st = FREE;
    else if (bad)    st = ERROR;
    else if (access) st = ACCESS;
  end

  assign ramstate = st;
  assign ramload  = (st == ACCESS && ramREN) ? mem[ridx] : 32'h0;
  assign tbload   = (tbREN && tb_ok) ? mem[tidx] : 32'h0;

  // A tb write always aborts the in-flight transaction so the arbiter re-reads fresh data.
  always_comb begin
    valid_d    = valid_q;
    lat_addr_d = lat_addr_q;
    lat_wen_d  = lat_wen_q;
    cnt_d      = cnt_q;
    if (tbWEN) begin
      valid_d = 1'b0;
    end else if (!req || bad) begin
      valid_d = 1'b0;
    end else if (!match) begin
      valid_d    = 1'b1;
      lat_addr_d = ramaddr;
      lat_wen_d  = ramWEN;
      cnt_d      = 4'(LAT - 1);
    end else if (cnt_q != 4'd0) begin
      cnt_d = cnt_q - 4'd1;
    end else begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid_q    <= 1'b0;
      lat_addr_q <= 32'h0;
      lat_wen_q  <= 1'b0;
      cnt_q      <= 4'd0;
    end else begin
      valid_q    <= valid_d;
      lat_addr_q <= lat_addr_d;
      lat_wen_q  <= lat_wen_d;
      cnt_q      <= cnt_d;
    end
  end

  // Array is deliberately outside the reset domain so contents survive nRST.
  always_ff @(posedge CLK) begin
    if (tbWEN) begin
      if (tb_ok) mem[tidx] <= tbstore;
    end else if (access && lat_wen_q) begin
      mem[ridx] <= ramstore;
    end
  end
endmodule

// File: tb/tb_ram_latency_model.sv
// Scoreboarded random + directed bench for ram_latency_model against a transaction-level model.
module tb_ram_latency_model;
  localparam int LAT = 2, DEPTH = 16384, IDX_W = 14;
  localparam logic [1:0] S_FREE = 2'd0, S_BUSY = 2'd1, S_ACCESS = 2'd2, S_ERROR = 2'd3;
  localparam logic [31:0] TOP_W = 32'(4 * DEPTH - 4);
  localparam logic [31:0] OOR   = 32'(4 * DEPTH);

  logic CLK = 1'b0, nRST = 1'b0;
  logic ramREN = 1'b0, ramWEN = 1'b0, tbWEN = 1'b0, tbREN = 1'b0;
  logic [31:0] ramaddr = '0, ramstore = '0, tbaddr = '0, tbstore = '0;
  logic [31:0] ramload, tbload;
  logic [1:0]  ramstate;

  ram_latency_model #(.LAT(LAT), .DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
    .CLK(CLK), .nRST(nRST), .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
    .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate), .tbWEN(tbWEN),
    .tbREN(tbREN), .tbaddr(tbaddr), .tbstore(tbstore), .tbload(tbload));

  always #5 CLK = ~CLK;

  typedef struct {
    logic [1:0]  st;
    logic [31:0] ld;
    logic [31:0] tl;
    string       tag;
  } exp_t;
  exp_t q[$];

  int total = 0, nbad = 0;

  // Reference model: memory image plus the one outstanding request and how many BUSY cycles it has shown.
  logic [31:0] mm [DEPTH];
  bit          pv = 0;
  logic [31:0] pa = '0;
  bit          pw = 0;
  int          seen = 0;

  logic [31:0] pool [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      nbad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
    end
  endtask

  always @(negedge CLK) begin : monitor
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk({e.tag, ".state"}, 32'(ramstate), 32'(e.st));
      chk({e.tag, ".ramload"}, ramload, e.ld);
      chk({e.tag, ".tbload"}, tbload, e.tl);
    end
  end

  function automatic bit in_range(input logic [31:0] a);
    return a[1:0] == 2'b00 && a[31:2] < 30'(DEPTH);
  endfunction

  // One cycle: drive just after posedge, predict this cycle's outputs, then advance the model at the edge.
  task automatic step(input bit rst, input bit ren, input bit wen, input logic [31:0] a,
                      input logic [31:0] s, input bit tbw, input bit tbr,
                      input logic [31:0] ta, input logic [31:0] ts, input string tag);
    exp_t e;
    bit req, badr, same;
    nRST = rst; ramREN = ren; ramWEN = wen; ramaddr = a; ramstore = s;
    tbWEN = tbw; tbREN = tbr; tbaddr = ta; tbstore = ts;
    req  = ren | wen;
    badr = (ren & wen) || !in_range(a);
    if (!rst) pv = 0;
    same = pv && req && !badr && a == pa && wen == pw;
    if (!rst || !req)                e.st = S_FREE;
    else if (badr)                   e.st = S_ERROR;
    else if (same && seen == LAT)    e.st = S_ACCESS;
    else                             e.st = S_BUSY;
    e.ld  = (e.st == S_ACCESS && ren) ? mm[a[IDX_W+1:2]] : 32'h0;
    e.tl  = (tbr && in_range(ta)) ? mm[ta[IDX_W+1:2]] : 32'h0;
    e.tag = tag;
    q.push_back(e);
    @(posedge CLK);
    if (rst) begin
      if (tbw) begin
        if (in_range(ta)) mm[ta[IDX_W+1:2]] = ts;
        pv = 0;
      end else if (e.st == S_FREE || e.st == S_ERROR) begin
        pv = 0;
      end else if (e.st == S_BUSY) begin
        if (same) seen++;
        else begin pv = 1; pa = a; pw = wen; seen = 1; end
      end else begin
        if (pw) mm[a[IDX_W+1:2]] = s;
        pv = 0;
      end
    end
    #1;
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0, tag);
  endtask

  task automatic dump(input string tag);
    for (int i = 0; i < 8; i++) step(1, 0, 0, 0, 0, 0, 1, pool[i], 0, tag);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    bit ren, wen, rst, tbw, tbr;
    logic [31:0] a, s, ta;
    int r;
    pool = '{32'h40, 32'h44, 32'h80, 32'h100, 32'h0, 32'h4, 32'h200, TOP_W};
    @(posedge CLK); #1;
    step(0, 1, 0, 32'h40, 0, 0, 0, 0, 0, "reset_req");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, "reset_idle");

    for (int i = 0; i < 8; i++) step(1, 0, 0, 0, 0, 1, 0, pool[i], $urandom, "preload");
    step(1, 0, 0, 0, 0, 1, 0, 32'h40, 32'hDEADBEEF, "preload40");
    dump("dump0");

    for (int i = 0; i < 4; i++) step(1, 1, 0, 32'h40, 0, 0, 0, 0, 0, "rd40");
    idle(1, "idle");

    for (int i = 0; i < 3; i++) step(1, 0, 1, 32'h100, 32'h12345678, 0, 0, 0, 0, "wr100");
    step(1, 0, 0, 0, 0, 0, 1, 32'h100, 0, "wr100_drop");

    step(1, 1, 0, 32'h40, 0, 0, 0, 0, 0, "sw40");
    for (int i = 0; i < 4; i++) step(1, 1, 0, 32'h44, 0, 0, 0, 0, 0, "sw44");
    idle(1, "idle");

    for (int i = 0; i < 3; i++) step(1, 1, 1, 32'h40, 32'h1, 0, 0, 0, 0, "err_both");
    for (int i = 0; i < 3; i++) step(1, 0, 1, 32'h42, 32'h2, 0, 0, 0, 0, "err_align");
    for (int i = 0; i < 3; i++) step(1, 0, 1, OOR, 32'h3, 0, 0, 0, 0, "err_range");
    dump("dump_err");

    step(1, 1, 0, 32'h40, 0, 0, 0, 0, 0, "tbw_rd");
    step(1, 1, 0, 32'h40, 0, 1, 0, 32'h40, 32'hCAFEF00D, "tbw_hit");
    for (int i = 0; i < 4; i++) step(1, 1, 0, 32'h40, 0, 0, 0, 0, 0, "tbw_after");

    step(1, 1, 0, TOP_W, 0, 0, 0, 0, 0, "top_rd");
    for (int i = 0; i < 3; i++) step(1, 1, 0, TOP_W, 0, 0, 0, 0, 0, "top_rd");

    for (int i = 0; i < 2; i++) step(1, 0, 1, 32'h80, 32'hAAAA5555, 0, 0, 0, 0, "rst_wr");
    step(0, 0, 1, 32'h80, 32'hAAAA5555, 0, 1, 32'h80, 0, "rst_in");
    step(1, 0, 0, 0, 0, 0, 1, 32'h80, 0, "rst_chk80");
    for (int i = 0; i < 4; i++) step(1, 0, 1, 32'h80, 32'hAAAA5555, 0, 0, 0, 0, "rst_after");
    step(1, 0, 0, 0, 0, 0, 1, 32'h80, 0, "rst_chk80b");

    ren = 0; wen = 0; a = 32'h40; s = 0;
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(99);
      if (r < 55) begin
      end else if (r < 75) begin
        ren = $urandom_range(1); wen = !ren; a = pool[$urandom_range(7)]; s = $urandom;
      end else if (r < 85) begin
        ren = 0; wen = 0;
      end else if (r < 92) begin
        case ($urandom_range(2))
          0: begin ren = 1; wen = 1; a = pool[$urandom_range(7)]; end
          1: begin ren = 0; wen = 1; a = pool[$urandom_range(7)] | 32'h2; end
          default: begin ren = 1; wen = 0; a = ($urandom_range(1) != 0) ? OOR : 32'hFFFFFFFC; end
        endcase
      end else begin
        s = $urandom;
      end
      rst = $urandom_range(199) != 0;
      tbw = rst && $urandom_range(19) == 0;
      tbr = $urandom_range(1);
      ta  = pool[$urandom_range(7)];
      step(rst, ren, wen, a, s, tbw, tbr, ta, $urandom, "rand");
    end
    idle(1, "idle");
    dump("dump_end");

    @(negedge CLK); #1;
    chk("drain", 32'(q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, nbad);
    $finish;
  end
endmodule
